i8085_bus_responder: RTL and testbench
======================================

// Module: i8085_bus_responder
// PURPOSE
//  Memory-mapped byte-wide RAM slave on the 8085 multiplexed bus; responder to the CPU's bus initiator.
//  Latches the address on ALE, decodes a window, inserts programmable wait states via READY.
//  Serves RD_n reads and WR_n writes. Sits beside the CPU inside system, clocked by the CPU CLK OUT.
//  AD bus split into ad_in/ad_out/ad_oe; top level builds the tristate.
// PARAMETERS
//  BASE_ADDR    16'h2000  first byte address of the decoded window (aligned to 2**MEM_AW)
//  MEM_AW       8         log2 of RAM depth in bytes (window = 2**MEM_AW bytes)
//  WAIT_STATES  1         Tw cycles inserted per selected access, 0..7
//  IO_M_SEL     1'b0      io_m value that selects this block (0 = memory space, 1 = I/O space)
// PORTS
//  clk_out    in   1  CPU clock; all state updates on rising edge
//  resetn_in  in   1  asynchronous active-low reset
//  ale        in   1  address latch enable, high in T1
//  io_m       in   1  1 = I/O cycle, 0 = memory cycle
//  a_hi       in   8  address A15..A8
//  ad_in      in   8  AD7..AD0 as seen on the bus
//  rd_n       in   1  read strobe, active low
//  wr_n       in   1  write strobe, active low
//  ad_out     out  8  read data driven onto AD7..AD0
//  ad_oe      out  1  1 = drive ad_out onto the bus
//  ready      out  1  0 = CPU inserts Tw; 1 = proceed
//  sel        out  1  latched decode hit for the current bus cycle
// BEHAVIOUR
//  Reset (async, resetn_in=0): state=IDLE, ad_oe=0, ad_out=8'h00, ready=1, sel=0, wait_cnt=0.
//   RAM contents are not reset. ad_oe drops the instant resetn_in falls (mid-access included).
//  ADDR latch: rising edge with ale=1 captures addr={a_hi,ad_in} and io_m;
//   sel<=(io_m==IO_M_SEL)&&(addr[15:MEM_AW]==BASE_ADDR[15:MEM_AW]). ale=1 in any state aborts the
//   current access: ad_oe<=0, state<=ADDR.
//  FSM: IDLE -> ADDR (ale seen) -> WAIT (sel && WAIT_STATES>0) or ACCESS (sel && WAIT_STATES==0);
//   ADDR with !sel -> IDLE. WAIT -> ACCESS when wait_cnt reaches 0. ACCESS -> IDLE once rd_n=1 && wr_n=1.
//  Wait states: on the ALE edge with a hit, ready<=0, wait_cnt<=WAIT_STATES-1; each WAIT cycle
//   decrements; at wait_cnt==0 ready<=1 the following edge. ready low exactly WAIT_STATES cycles
//   starting the cycle after ALE (covers T2 sampling). !sel or WAIT_STATES==0: ready stays 1.
//  Read: in ACCESS with rd_n=0, wr_n=1: ad_out<=mem[addr[MEM_AW-1:0]], ad_oe<=1 (1-cycle latency
//   from ACCESS entry); held until rd_n=1, then ad_oe<=0 on that edge.
//  Write: in ACCESS, first edge with wr_n=0, rd_n=1: mem[addr]<=ad_in; one write per bus cycle.
//  rd_n=0 && wr_n=0 together: illegal; no write, ad_oe=0, state->IDLE.
//  Strobe asserted without a prior hit ALE: ignored, no drive, no write.
//  Address wrap: only addr[MEM_AW-1:0] indexes RAM; no wrap past window end (decode fails instead).
//  ad_oe never 1 while wr_n=0, in IDLE, or in ADDR.
// STRUCTURE
//  Package i8085_bus_pkg: typedef enum {IDLE,ADDR,WAIT,ACCESS} resp_state_t; localparam
//   AD_W=8, ADDR_W=16; used also by the CPU bus unit and other bus slaves.
//  Sub-module i8085_resp_ram: single-port synchronous RAM, depth 2**MEM_AW x 8, registered read,
//   write enable; no reset. FSM, decode, wait counter stay in the top module.
// TESTING
//  1 Hold resetn_in=0 560 ns, release -> ready=1, ad_oe=0, sel=0, ad_out=8'h00 throughout.
//  2 Write 8'h5A to 16'h2005 (io_m=0, WAIT_STATES=1) -> ready=0 for exactly 1 cycle after ALE;
//    then read 16'h2005 -> ad_oe=1 while rd_n=0, ad_out=8'h5A, ad_oe=0 the edge after rd_n rises.
//  3 Read 16'h3000 and I/O read (io_m=1) at 16'h2000 -> sel=0, ready stays 1, ad_oe stays 0.
//  4 WAIT_STATES=3 read of 16'h20FF -> ready low exactly 3 cycles; WAIT_STATES=0 -> ready never low.
//  5 Drop resetn_in during ACCESS with ad_oe=1 -> ad_oe=0 immediately; next read after release
//    still returns previously written 8'h5A at 16'h2005.
//  6 rd_n=0 and wr_n=0 together at 16'h2010 holding 8'h11, ad_in=8'hEE -> no drive; later read = 8'h11.

Source files
------------

// File: rtl/i8085_bus_pkg.sv
// Shared 8085 bus definitions: responder state encoding, bus widths and window decode helper.
package i8085_bus_pkg;

  localparam int AD_W   = 8;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    ACCESS
  } resp_state_t;

  // True when addr falls in the 2**aw byte window that starts at base (base aligned to 2**aw).
  function automatic logic window_hit(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input int                aw);
    return (addr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/i8085_resp_ram.sv
// Single-port byte RAM with registered read for the 8085 bus responder; contents are never reset.
module i8085_resp_ram
  import i8085_bus_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [AD_W-1:0] mem [2**MEM_AW];
  logic [AD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/i8085_bus_responder.sv
// Byte-wide RAM slave on the 8085 multiplexed AD bus: ALE address latch, window decode,
// programmable READY wait states, and RD_n/WR_n data transfer.
module i8085_bus_responder
  import i8085_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h2000,
  parameter int          MEM_AW      = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic        IO_M_SEL    = 1'b0
) (
  input  logic       clk_out,
  input  logic       resetn_in,
  input  logic       ale,
  input  logic       io_m,
  input  logic [7:0] a_hi,
  input  logic [7:0] ad_in,
  input  logic       rd_n,
  input  logic       wr_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ready,
  output logic       sel
);

  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [2:0] WAIT_INIT = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

  resp_state_t       state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              sel_q, sel_d;
  logic              ready_q, ready_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic              ad_oe_q, ad_oe_d;
  logic [AD_W-1:0]   ad_out_q, ad_out_d;
  logic              wrote_q, wrote_d;

  logic [ADDR_W-1:0] bus_addr;
  logic              hit;
  logic              ram_we;
  logic [AD_W-1:0]   ram_rdata;

  assign bus_addr = {a_hi, ad_in};
  assign hit      = (io_m == IO_M_SEL) && window_hit(bus_addr, BASE_ADDR, MEM_AW);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    ready_d    = ready_q;
    wait_cnt_d = wait_cnt_q;
    ad_oe_d    = ad_oe_q;
    ad_out_d   = ad_out_q;
    wrote_d    = wrote_q;
    ram_we     = 1'b0;

    if (ale) begin
      state_d = ADDR;
      addr_d  = bus_addr[MEM_AW-1:0];
      sel_d   = hit;
      ad_oe_d = 1'b0;
      wrote_d = 1'b0;
      if (hit && HAS_WAIT) begin
        ready_d    = 1'b0;
        wait_cnt_d = WAIT_INIT;
      end else begin
        ready_d    = 1'b1;
        wait_cnt_d = 3'd0;
      end
    end else begin
      // The wait countdown runs from the ALE edge regardless of state so READY covers T2 sampling.
      if (!ready_q) begin
        if (wait_cnt_q == 3'd0) begin
          ready_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end

      case (state_q)
        IDLE: begin
          ad_oe_d = 1'b0;
        end
        ADDR: begin
          if (!sel_q) begin
            state_d = IDLE;
          end else if (HAS_WAIT) begin
            state_d = WAIT;
          end else begin
            state_d = ACCESS;
          end
        end
        WAIT: begin
          if (wait_cnt_q == 3'd0) begin
            state_d = ACCESS;
          end
        end
        ACCESS: begin
          if (!rd_n && !wr_n) begin
            ad_oe_d = 1'b0;
            state_d = IDLE;
          end else if (!rd_n) begin
            ad_out_d = ram_rdata;
            ad_oe_d  = 1'b1;
          end else if (!wr_n) begin
            ad_oe_d = 1'b0;
            if (!wrote_q) begin
              ram_we  = 1'b1;
              wrote_d = 1'b1;
            end
          end else begin
            ad_oe_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          ad_oe_d = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_out or negedge resetn_in) begin
    if (!resetn_in) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      sel_q      <= 1'b0;
      ready_q    <= 1'b1;
      wait_cnt_q <= 3'd0;
      ad_oe_q    <= 1'b0;
      ad_out_q   <= '0;
      wrote_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      ready_q    <= ready_d;
      wait_cnt_q <= wait_cnt_d;
      ad_oe_q    <= ad_oe_d;
      ad_out_q   <= ad_out_d;
      wrote_q    <= wrote_d;
    end
  end

  i8085_resp_ram #(
    .MEM_AW(MEM_AW)
  ) u_ram (
    .clk  (clk_out),
    .we   (ram_we),
    .addr (addr_q),
    .wdata(ad_in),
    .rdata(ram_rdata)
  );

  // Never contend with the CPU: a low WR_n masks the driver even before the next edge.
  assign ad_oe  = ad_oe_q & wr_n;
  assign ad_out = ad_out_q;
  assign ready  = ready_q;
  assign sel    = sel_q;

endmodule

// File: tb/tb_i8085_bus_responder.sv
// Bench for i8085_bus_responder: three instances (1, 3 and 0 wait states) share one bus and are
// checked against a byte-array RAM model with window decode done by plain address comparison.
module tb_i8085_bus_responder;

  localparam int HOLD = 8;

  logic       clk_out   = 1'b0;
  logic       resetn_in = 1'b1;
  logic       ale       = 1'b0;
  logic       io_m      = 1'b0;
  logic [7:0] a_hi      = 8'h00;
  logic [7:0] ad_in     = 8'h00;
  logic       rd_n      = 1'b1;
  logic       wr_n      = 1'b1;

  logic [7:0] ad_out_w [3];
  logic       ad_oe_w  [3];
  logic       ready_w  [3];
  logic       sel_w    [3];

  logic [7:0] model_mem   [256];
  bit         model_known [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_out = ~clk_out;

  i8085_bus_responder #(.BASE_ADDR(16'h2000), .MEM_AW(8), .WAIT_STATES(1), .IO_M_SEL(1'b0)) u_dut1 (
    .clk_out(clk_out), .resetn_in(resetn_in), .ale(ale), .io_m(io_m), .a_hi(a_hi), .ad_in(ad_in),
    .rd_n(rd_n), .wr_n(wr_n), .ad_out(ad_out_w[0]), .ad_oe(ad_oe_w[0]), .ready(ready_w[0]), .sel(sel_w[0]));

  i8085_bus_responder #(.BASE_ADDR(16'h2000), .MEM_AW(8), .WAIT_STATES(3), .IO_M_SEL(1'b0)) u_dut3 (
    .clk_out(clk_out), .resetn_in(resetn_in), .ale(ale), .io_m(io_m), .a_hi(a_hi), .ad_in(ad_in),
    .rd_n(rd_n), .wr_n(wr_n), .ad_out(ad_out_w[1]), .ad_oe(ad_oe_w[1]), .ready(ready_w[1]), .sel(sel_w[1]));

  i8085_bus_responder #(.BASE_ADDR(16'h2000), .MEM_AW(8), .WAIT_STATES(0), .IO_M_SEL(1'b0)) u_dut0 (
    .clk_out(clk_out), .resetn_in(resetn_in), .ale(ale), .io_m(io_m), .a_hi(a_hi), .ad_in(ad_in),
    .rd_n(rd_n), .wr_n(wr_n), .ad_out(ad_out_w[2]), .ad_oe(ad_oe_w[2]), .ready(ready_w[2]), .sel(sel_w[2]));

  function automatic int wsOf(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit modelHit(input logic [15:0] addr, input logic iom);
    return (iom == 1'b0) && (addr >= 16'h2000) && (addr <= 16'h20FF);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // kind: 0 = read, 1 = write, 2 = illegal (RD_n and WR_n together)
  task automatic applyStimulus(input logic [15:0] addr, input logic iom, input int kind, input logic [7:0] wdat);
    bit         hit;
    bit         known;
    logic [7:0] exp_data;
    logic [7:0] low_mask [3];
    logic       first_oe [3];
    logic       any_oe   [3];
    logic       last_oe  [3];
    logic [7:0] last_out [3];
    logic [7:0] exp_mask;

    hit      = modelHit(addr, iom);
    known    = model_known[addr[7:0]];
    exp_data = model_mem[addr[7:0]];

    @(negedge clk_out);
    ale  = 1'b1;
    a_hi = addr[15:8];
    ad_in = addr[7:0];
    io_m = iom;
    rd_n = 1'b1;
    wr_n = 1'b1;
    @(negedge clk_out);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("sel%0d_%h", i, addr), 32'(sel_w[i]), 32'(hit));
      low_mask[i] = 8'h00;
      any_oe[i]   = 1'b0;
    end

    for (int k = 0; k < HOLD; k++) begin
      for (int i = 0; i < 3; i++) begin
        low_mask[i][k] = (ready_w[i] !== 1'b1);
        if (k == 0) first_oe[i] = ad_oe_w[i];
        if (ad_oe_w[i] !== 1'b0) any_oe[i] = 1'b1;
        last_oe[i]  = ad_oe_w[i];
        last_out[i] = ad_out_w[i];
      end
      if (k == 0) begin
        ale   = 1'b0;
        ad_in = (kind == 0) ? 8'($urandom) : wdat;
        rd_n  = !(kind == 0 || kind == 2);
        wr_n  = !(kind == 1 || kind == 2);
      end
      @(negedge clk_out);
    end

    rd_n = 1'b1;
    wr_n = 1'b1;
    @(negedge clk_out);

    for (int i = 0; i < 3; i++) begin
      exp_mask = hit ? 8'((1 << wsOf(i)) - 1) : 8'h00;
      checkOutput($sformatf("ready_mask%0d_%h", i, addr), 32'(low_mask[i]), 32'(exp_mask));
      checkOutput($sformatf("oe_in_addr%0d_%h", i, addr), 32'(first_oe[i]), 32'd0);
      if (kind == 0 && hit) begin
        checkOutput($sformatf("rd_oe%0d_%h", i, addr), 32'(last_oe[i]), 32'd1);
        if (known) checkOutput($sformatf("rd_data%0d_%h", i, addr), 32'(last_out[i]), 32'(exp_data));
      end else begin
        checkOutput($sformatf("no_drive%0d_%h", i, addr), 32'(any_oe[i]), 32'd0);
      end
      checkOutput($sformatf("oe_release%0d_%h", i, addr), 32'(ad_oe_w[i]), 32'd0);
    end

    if (kind == 1 && hit) begin
      model_mem[addr[7:0]]   = wdat;
      model_known[addr[7:0]] = 1'b1;
    end
  endtask

  initial begin
    int          waited;
    int          r;
    int          kind;
    logic [15:0] r_addr;
    logic        r_iom;

    $display("[TB] start");
    #1 resetn_in = 1'b0;
    repeat (56) begin
      @(negedge clk_out);
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("rst_ready%0d", i), 32'(ready_w[i]), 32'd1);
        checkOutput($sformatf("rst_oe%0d", i), 32'(ad_oe_w[i]), 32'd0);
        checkOutput($sformatf("rst_sel%0d", i), 32'(sel_w[i]), 32'd0);
        checkOutput($sformatf("rst_out%0d", i), 32'(ad_out_w[i]), 32'h00);
      end
    end
    #1 resetn_in = 1'b1;
    repeat (3) begin
      @(negedge clk_out);
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("post_rst_ready%0d", i), 32'(ready_w[i]), 32'd1);
        checkOutput($sformatf("post_rst_oe%0d", i), 32'(ad_oe_w[i]), 32'd0);
        checkOutput($sformatf("post_rst_out%0d", i), 32'(ad_out_w[i]), 32'h00);
      end
    end

    $display("[TB] write/read 0x2005");
    applyStimulus(16'h2005, 1'b0, 1, 8'h5A);
    applyStimulus(16'h2005, 1'b0, 0, 8'h00);

    $display("[TB] strobes without ALE");
    @(negedge clk_out);
    wr_n  = 1'b0;
    ad_in = 8'hFF;
    repeat (3) begin
      @(negedge clk_out);
      for (int i = 0; i < 3; i++) checkOutput($sformatf("stray_wr_oe%0d", i), 32'(ad_oe_w[i]), 32'd0);
    end
    wr_n = 1'b1;
    rd_n = 1'b0;
    repeat (3) begin
      @(negedge clk_out);
      for (int i = 0; i < 3; i++) checkOutput($sformatf("stray_rd_oe%0d", i), 32'(ad_oe_w[i]), 32'd0);
    end
    rd_n = 1'b1;

    $display("[TB] decode misses");
    applyStimulus(16'h3000, 1'b0, 0, 8'h00);
    applyStimulus(16'h2000, 1'b1, 0, 8'h00);

    $display("[TB] window edges");
    applyStimulus(16'h20FF, 1'b0, 1, 8'($urandom));
    applyStimulus(16'h20FF, 1'b0, 0, 8'h00);
    applyStimulus(16'h2100, 1'b0, 0, 8'h00);
    applyStimulus(16'h1FFF, 1'b0, 1, 8'h77);

    $display("[TB] illegal strobes");
    applyStimulus(16'h2010, 1'b0, 1, 8'h11);
    applyStimulus(16'h2010, 1'b0, 2, 8'hEE);
    applyStimulus(16'h2010, 1'b0, 0, 8'h00);

    $display("[TB] reset during read");
    @(negedge clk_out);
    ale   = 1'b1;
    a_hi  = 8'h20;
    ad_in = 8'h05;
    io_m  = 1'b0;
    @(negedge clk_out);
    ale  = 1'b0;
    rd_n = 1'b0;
    waited = 0;
    while (ad_oe_w[0] !== 1'b1 && waited < 12) begin
      @(negedge clk_out);
      waited++;
    end
    checkOutput("mid_read_oe", 32'(ad_oe_w[0]), 32'd1);
    #2 resetn_in = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("async_oe_drop%0d", i), 32'(ad_oe_w[i]), 32'd0);
      checkOutput($sformatf("async_ready%0d", i), 32'(ready_w[i]), 32'd1);
    end
    @(negedge clk_out);
    @(negedge clk_out);
    rd_n      = 1'b1;
    resetn_in = 1'b1;
    applyStimulus(16'h2005, 1'b0, 0, 8'h00);

    $display("[TB] random bus cycles");
    repeat (40) begin
      r      = $urandom_range(0, 9);
      r_addr = (r < 8) ? {8'h20, 3'b000, 5'($urandom)} : 16'($urandom);
      r_iom  = ($urandom_range(0, 7) == 0);
      r      = $urandom_range(0, 9);
      kind   = (r < 5) ? 0 : ((r < 9) ? 1 : 2);
      applyStimulus(r_addr, r_iom, kind, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
